// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin pick helper for the memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 16;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;
    localparam int unsigned RR_SUM_W   = RR_IDX_W + 1;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] adr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // First set bit of valid at or after ptr, wrapping modulo num_req; returns ptr if none.
    function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                                    input logic [RR_IDX_W-1:0]   ptr,
                                                    input int unsigned           num_req);
        logic [RR_SUM_W-1:0] idx;
        logic                hit;
        rr_pick = ptr;
        hit     = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            idx = {1'b0, ptr} + RR_SUM_W'(i);
            if (idx >= RR_SUM_W'(num_req)) begin
                idx = idx - RR_SUM_W'(num_req);
            end
            if (!hit && (i < num_req) && valid[idx[RR_IDX_W-1:0]]) begin
                rr_pick = idx[RR_IDX_W-1:0];
                hit     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick from a request vector, starting at ptr.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] pick_c,
    output logic          found_c
);

    assign pick_c  = PW'(rr_pick(RR_MAX_REQ'(req), RR_IDX_W'(ptr), N));
    assign found_c = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between NUM_REQ cache ports, round-robin,
// with a watchdog that aborts transfers memory never acknowledges.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_adr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [DATA_WIDTH-1:0]         req_rdata_o,
    output logic [NUM_REQ-1:0]            req_err_o,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_adr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_idx_o,
    output logic                          busy_o
);

    localparam int unsigned IW       = $clog2(NUM_REQ);
    localparam int unsigned TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_LAST = WDOG_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TW-1:0] TMR_MAX  = '1;

    arb_state_t              state;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           gnt;
    logic [TW-1:0]           timer;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic [IW-1:0]           pick_c;
    logic                    found_c;
    logic [IW-1:0]           next_ptr_c;
    logic                    busy_c;
    logic                    tmo_c;
    logic                    done_c;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid_i),
        .ptr     (rr_ptr),
        .pick_c  (pick_c),
        .found_c (found_c)
    );

    assign next_ptr_c = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + IW'(1);

    // Memory-side outputs come straight from state and capture registers only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            gnt     <= '0;
            timer   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (found_c) begin
                        gnt     <= pick_c;
                        we_q    <= req_we_i[pick_c];
                        adr_q   <= req_adr_i[pick_c*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q <= req_wdata_i[pick_c*DATA_WIDTH +: DATA_WIDTH];
                        timer   <= '0;
                        state   <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (done_c) begin
                        rr_ptr <= next_ptr_c;
                        state  <= ARB_IDLE;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Completion and abort pulses are same-cycle with the memory acknowledge.
    assign busy_c      = (state == ARB_BUSY);
    assign tmo_c       = WDOG_EN && busy_c && !mem_ready_i && (timer == TMO_LAST);
    assign done_c      = busy_c && (mem_ready_i || tmo_c);

    assign busy_o      = busy_c;
    assign mem_valid_o = busy_c;
    assign mem_we_o    = we_q;
    assign mem_adr_o   = adr_q;
    assign mem_wdata_o = wdata_q;
    assign gnt_idx_o   = gnt;
    assign req_ready_o = done_c ? (NUM_REQ'(1) << gnt) : '0;
    assign req_err_o   = tmo_c ? (NUM_REQ'(1) << gnt) : '0;
    assign req_rdata_o = (busy_c && mem_ready_i) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-requester expected queues,
// a latency-programmable memory responder and grant/length sequence logs.
module tb_mem_port_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int TMO = 8;

    typedef struct {
        bit          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdata;
        bit          err;
    } exp_t;

    logic              clk_i       = 1'b0;
    logic              rst_i       = 1'b1;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic [NR-1:0]     req_we_i    = '0;
    logic [NR*AW-1:0]  req_adr_i   = '0;
    logic [NR*DW-1:0]  req_wdata_i = '0;
    logic [DW-1:0]     req_rdata_o;
    logic [NR-1:0]     req_err_o;
    logic              mem_valid_o;
    logic              mem_ready_i = 1'b0;
    logic              mem_we_o;
    logic [AW-1:0]     mem_adr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW-1:0]     mem_rdata_i = '0;
    logic [0:0]        gnt_idx_o;
    logic              busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int mem_delay = 1;
    int bcnt = 0;
    int nval = 0;
    bit prev_valid = 1'b0;
    bit prev_done  = 1'b0;
    bit scramble [NR] = '{default: 1'b0};

    exp_t          pend_q [NR][$];
    int            gseq[$];
    int            lseq[$];
    logic [AW-1:0] aseq[$];

    mem_port_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_wdata_i(req_wdata_i), .req_rdata_o(req_rdata_o),
        .req_err_o(req_err_o), .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .gnt_idx_o(gnt_idx_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ DW'(a ^ 16'h0040);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_i);
            #2;
        end
    endtask

    task automatic enq(input int r, input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] wd);
        exp_t e;
        e.we    = we;
        e.adr   = adr;
        e.wdata = wd;
        e.err   = (mem_delay == 0) || (mem_delay > TMO);
        pend_q[r].push_back(e);
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 200) begin
            step(1);
            k++;
        end
        check_eq("done_wait", 64'(done_cnt >= target), 1);
    endtask

    task automatic clr_seq();
        gseq.delete();
        lseq.delete();
        aseq.delete();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_mem_valid"}, mem_valid_o, 0);
        check_eq({tag, "_busy"},      busy_o, 0);
        check_eq({tag, "_ready"},     req_ready_o, 0);
        check_eq({tag, "_err"},       req_err_o, 0);
        check_eq({tag, "_rdata"},     req_rdata_o, 0);
        check_eq({tag, "_we"},        mem_we_o, 0);
        check_eq({tag, "_adr"},       mem_adr_o, 0);
        check_eq({tag, "_wdata"},     mem_wdata_o, 0);
        check_eq({tag, "_gnt"},       gnt_idx_o, 0);
    endtask

    // One-cycle reset; requesters in clr_mask abandon their pending request.
    task automatic do_reset(input logic [NR-1:0] clr_mask);
        rst_i = 1'b1;
        for (int i = 0; i < NR; i++) if (clr_mask[i]) pend_q[i].delete();
        step(1);
        check_zero("rst");
        rst_i = 1'b0;
    endtask

    // Memory model: acknowledges on the mem_delay-th BUSY cycle (0 = never).
    always @(posedge clk_i) begin
        #1;
        if (mem_valid_o) begin
            bcnt++;
            mem_ready_i = (mem_delay != 0) && (bcnt == mem_delay);
            mem_rdata_i = mem_ready_i ? rd_model(mem_adr_o) : $urandom;
        end else begin
            bcnt        = 0;
            mem_ready_i = 1'b0;
            mem_rdata_i = $urandom;
        end
    end

    // Monitor then requester driver, both on the falling edge.
    always @(negedge clk_i) begin
        int   r;
        int   done_r;
        exp_t e;
        done_r = -1;
        if (rst_i) begin
            prev_valid = 1'b0;
            prev_done  = 1'b0;
            nval       = 0;
        end else begin
            if (prev_done) check_eq("bubble_valid", mem_valid_o, 0);
            prev_done = 1'b0;
            if (mem_valid_o) begin
                nval++;
                if (!prev_valid) begin
                    gseq.push_back(int'(gnt_idx_o));
                    aseq.push_back(mem_adr_o);
                end
                r = int'(gnt_idx_o);
                if (pend_q[r].size() == 0) begin
                    check_eq("grant_without_req", 1, 0);
                end else begin
                    e = pend_q[r][0];
                    check_eq("mem_adr", mem_adr_o, e.adr);
                    check_eq("mem_we", mem_we_o, e.we);
                    check_eq("mem_wdata", mem_wdata_o, e.wdata);
                end
            end
            if (req_ready_o != '0) begin
                r = req_ready_o[0] ? 0 : 1;
                check_eq("ready_onehot", req_ready_o, NR'(1) << r);
                if (pend_q[r].size() == 0) begin
                    check_eq("ready_without_req", 1, 0);
                end else begin
                    e = pend_q[r].pop_front();
                    check_eq("req_err", req_err_o, e.err ? (NR'(1) << r) : NR'(0));
                    check_eq("req_rdata", req_rdata_o, e.err ? DW'(0) : rd_model(e.adr));
                end
                lseq.push_back(nval);
                nval      = 0;
                done_cnt++;
                prev_done = 1'b1;
                done_r    = r;
            end else begin
                check_eq("err_without_ready", req_err_o, 0);
            end
            prev_valid = mem_valid_o;
        end
        for (int i = 0; i < NR; i++) begin
            if (!rst_i && scramble[i] && mem_valid_o && int'(gnt_idx_o) == i && done_r != i) begin
                req_valid_i[i]           = 1'($urandom_range(0, 1));
                req_adr_i[i*AW +: AW]    = AW'($urandom);
                req_wdata_i[i*DW +: DW]  = $urandom;
            end else if (pend_q[i].size() != 0) begin
                req_valid_i[i]           = 1'b1;
                req_we_i[i]              = pend_q[i][0].we;
                req_adr_i[i*AW +: AW]    = pend_q[i][0].adr;
                req_wdata_i[i*DW +: DW]  = pend_q[i][0].wdata;
            end else begin
                req_valid_i[i]           = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        step(3);
        check_zero("por");
        rst_i = 1'b0;

        // Single read, memory answers on the 3rd BUSY cycle.
        clr_seq();
        mem_delay = 3;
        enq(0, 1'b0, 16'h0040, 32'h0);
        wait_done(1);
        check_eq("t1_ngnt", gseq.size(), 1);
        check_eq("t1_gnt", gseq.size() > 0 ? gseq[0] : -1, 0);
        check_eq("t1_len", lseq.size() > 0 ? lseq[0] : -1, 3);
        check_eq("t1_adr", aseq.size() > 0 ? aseq[0] : 16'hFFFF, 16'h0040);

        // Simultaneous requests straight after reset.
        do_reset('1);
        clr_seq();
        mem_delay = 1;
        enq(0, 1'b1, 16'h0010, 32'h11111111);
        enq(1, 1'b0, 16'h0020, 32'h22222222);
        wait_done(3);
        check_eq("t2_ngnt", gseq.size(), 2);
        check_eq("t2_gnt0", gseq.size() > 0 ? gseq[0] : -1, 0);
        check_eq("t2_gnt1", gseq.size() > 1 ? gseq[1] : -1, 1);
        check_eq("t2_adr0", aseq.size() > 0 ? aseq[0] : 16'hFFFF, 16'h0010);
        check_eq("t2_adr1", aseq.size() > 1 ? aseq[1] : 16'hFFFF, 16'h0020);
        check_eq("t2_len1", lseq.size() > 1 ? lseq[1] : -1, 1);

        // Both requesters continuously valid: strict alternation.
        clr_seq();
        for (int j = 0; j < 3; j++) begin
            enq(0, 1'b0, AW'(16'h0100 + j), 32'hA0A0_0000 + DW'(j));
            enq(1, 1'b1, AW'(16'h0200 + j), 32'hB0B0_0000 + DW'(j));
        end
        wait_done(9);
        check_eq("t3_ngnt", gseq.size(), 6);
        for (int j = 0; j < 6; j++) begin
            check_eq($sformatf("t3_gnt%0d", j), gseq.size() > j ? gseq[j] : -1, j % 2);
        end

        // Watchdog abort, then a normal transfer.
        clr_seq();
        mem_delay = 0;
        enq(0, 1'b0, 16'h0080, 32'h0);
        wait_done(10);
        step(1);
        mem_delay = 2;
        enq(1, 1'b0, 16'h0090, 32'h0);
        wait_done(11);
        check_eq("t4_len_tmo", lseq.size() > 0 ? lseq[0] : -1, TMO);
        check_eq("t4_len_ok", lseq.size() > 1 ? lseq[1] : -1, 2);
        check_eq("t4_gnt1", gseq.size() > 1 ? gseq[1] : -1, 1);

        // Requester scrambles its bus while granted; memory side must not move.
        clr_seq();
        scramble[1] = 1'b1;
        mem_delay = 4;
        enq(1, 1'b1, 16'h00A0, 32'hCAFEF00D);
        wait_done(12);
        scramble[1] = 1'b0;
        check_eq("t5_len", lseq.size() > 0 ? lseq[0] : -1, 4);
        check_eq("t5_gnt", gseq.size() > 0 ? gseq[0] : -1, 1);

        // Reset during BUSY; the pending req1 is served afterwards.
        clr_seq();
        mem_delay = 0;
        enq(0, 1'b0, 16'h00B0, 32'h0);
        k = 0;
        while (!mem_valid_o && k < 20) begin
            step(1);
            k++;
        end
        check_eq("t6_busy_seen", mem_valid_o, 1);
        step(2);
        mem_delay = 1;
        enq(1, 1'b0, 16'h00C0, 32'h0);
        step(1);
        do_reset(2'b01);
        clr_seq();
        wait_done(13);
        check_eq("t6_gnt", gseq.size() > 0 ? gseq[0] : -1, 1);
        check_eq("t6_adr", aseq.size() > 0 ? aseq[0] : 16'hFFFF, 16'h00C0);

        step(3);
        check_eq("pend0_empty", pend_q[0].size(), 0);
        check_eq("pend1_empty", pend_q[1].size(), 0);
        check_eq("done_total", done_cnt, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
